// File: rtl/upower_xo_fetch_decode_pkg.sv
// Shared constants for the uPower XO-format fetch/decode stage: opcodes, FSM encodings and
// instruction field positions.
package upower_xo_fetch_decode_pkg;

  localparam int unsigned PO_XO = 31;

  localparam logic [8:0] XO_ADD  = 9'd266;
  localparam logic [8:0] XO_SUBF = 9'd40;
  localparam logic [8:0] XO_AND  = 9'd28;
  localparam logic [8:0] XO_OR   = 9'd444;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StOut    = 3'd3;
  localparam logic [2:0] StHalt   = 3'd4;

  localparam int unsigned PO_MSB = 31;
  localparam int unsigned PO_LSB = 26;
  localparam int unsigned RT_MSB = 25;
  localparam int unsigned RT_LSB = 21;
  localparam int unsigned RA_MSB = 20;
  localparam int unsigned RA_LSB = 16;
  localparam int unsigned RB_MSB = 15;
  localparam int unsigned RB_LSB = 11;
  localparam int unsigned OE_BIT = 10;
  localparam int unsigned XO_MSB = 9;
  localparam int unsigned XO_LSB = 1;
  localparam int unsigned RC_BIT = 0;

  function automatic logic xo_known(input logic [8:0] xo);
    return (xo == XO_ADD) || (xo == XO_SUBF) || (xo == XO_AND) || (xo == XO_OR);
  endfunction

endpackage

// File: rtl/upower_imem.sv
// Word-addressed instruction RAM: one write port, synchronous read with one-cycle latency.
module upower_imem #(
  parameter int unsigned Depth = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [Depth];

  // Read samples the array before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/upower_xo_fetch_decode.sv
// Instruction-supply stage: steps a word PC through the instruction RAM, splits each word
// into XO-format fields and presents them on a valid/ready handshake.
module upower_xo_fetch_decode
  import upower_xo_fetch_decode_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned AW         = 6,
  parameter int unsigned XO_PO      = PO_XO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_wdata,
  input  logic          start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   pc_out,
  output logic [5:0]    po,
  output logic [4:0]    rt,
  output logic [4:0]    ra,
  output logic [4:0]    rb,
  output logic          oe,
  output logic [8:0]    xo,
  output logic          rc,
  output logic          illegal,
  output logic          busy,
  output logic          done
);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_out_q;
  logic [31:0]   rdata, instr_q;
  logic          valid_q, illegal_q, illegal_c;
  logic          load_out, clear_valid;

  upower_imem #(
    .Depth (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_addr),
    .wdata (imem_wdata),
    .re    (state_q == StFetch),
    .raddr (pc_q),
    .rdata (rdata)
  );

  always_comb begin
    illegal_c = (rdata[PO_MSB:PO_LSB] != 6'(XO_PO)) || !xo_known(rdata[XO_MSB:XO_LSB]);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_out    = 1'b0;
    clear_valid = 1'b0;
    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch:  state_d = StDecode;
      StDecode: begin
        load_out = 1'b1;
        state_d  = StOut;
      end
      StOut: begin
        if (out_ready) begin
          clear_valid = 1'b1;
          // The last word ends the run; the PC never wraps back to 0.
          if (illegal_q || (pc_q == AW'(IMEM_DEPTH - 1))) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      pc_out_q  <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (load_out) begin
        instr_q   <= rdata;
        illegal_q <= illegal_c;
        pc_out_q  <= pc_q;
        valid_q   <= 1'b1;
      end else if (clear_valid) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = {{(64 - AW - 2){1'b0}}, pc_out_q, 2'b00};
  assign po        = instr_q[PO_MSB:PO_LSB];
  assign rt        = instr_q[RT_MSB:RT_LSB];
  assign ra        = instr_q[RA_MSB:RA_LSB];
  assign rb        = instr_q[RB_MSB:RB_LSB];
  assign oe        = instr_q[OE_BIT];
  assign xo        = instr_q[XO_MSB:XO_LSB];
  assign rc        = instr_q[RC_BIT];
  assign illegal   = illegal_q;
  assign busy      = (state_q == StFetch) || (state_q == StDecode) || (state_q == StOut);
  assign done      = (state_q == StHalt);

endmodule

// File: tb/tb_upower_xo_fetch_decode.sv
// Bench for upower_xo_fetch_decode: directed program runs plus randomized traffic, all checked
// every cycle against a beat-level reference model.
module tb_upower_xo_fetch_decode;

  logic        clk, rst, imem_we, start, out_ready;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        out_valid, oe, rc, illegal, busy, done;
  logic [63:0] pc_out;
  logic [5:0]  po;
  logic [4:0]  rt, ra, rb;
  logic [8:0]  xo;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  upower_xo_fetch_decode #(
    .IMEM_DEPTH (64),
    .AW         (6),
    .XO_PO      (31)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .start      (start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc_out     (pc_out),
    .po         (po),
    .rt         (rt),
    .ra         (ra),
    .rb         (rb),
    .oe         (oe),
    .xo         (xo),
    .rc         (rc),
    .illegal    (illegal),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which word is being presented and how many edges remain until
  // the next presentation; fields come straight from the word by the ISA bit layout.
  logic [31:0] ref_mem [64];
  bit          m_valid = 0, m_halted = 0, m_ill = 0;
  int          m_gap = 0, m_idx = 0;
  logic [31:0] m_word = '0;

  function automatic bit is_illegal(input logic [31:0] w);
    int p, x;
    p = int'(w >> 26);
    x = int'((w >> 1) & 32'h1ff);
    return (p != 31) || !(x == 266 || x == 40 || x == 28 || x == 444);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_halted = 0; m_gap = 0; m_idx = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0;
        if (m_ill || m_idx == 63) m_halted = 1;
        else begin
          m_idx++;
          m_gap = 2;
        end
      end
    end else if (m_gap == 2) begin
      m_word = ref_mem[m_idx];
      m_gap  = 1;
    end else if (m_gap == 1) begin
      m_gap   = 0;
      m_valid = 1;
      m_ill   = is_illegal(m_word);
    end else if (start) begin
      m_idx = 0; m_gap = 2; m_halted = 0;
    end
    if (imem_we) ref_mem[imem_addr] = imem_wdata;
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("valid", out_valid, m_valid);
      check("busy", busy, (m_valid || m_gap > 0));
      check("done", done, m_halted);
      if (m_valid && out_valid === 1'b1) begin
        check("pc_out", pc_out, 64'(m_idx * 4));
        check("po", po, m_word[31:26]);
        check("rt", rt, m_word[25:21]);
        check("ra", ra, m_word[20:16]);
        check("rb", rb, m_word[15:11]);
        check("oe", oe, m_word[10]);
        check("xo", xo, m_word[9:1]);
        check("rc", rc, m_word[0]);
        check("illegal", illegal, m_ill);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    imem_addr = 6'(a); imem_wdata = d; imem_we = 1'b1;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(name, out_valid, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, done, 1'b1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [8:0] x;
    if ($urandom % 8 == 0) return $urandom;
    case ($urandom % 4)
      0: x = 9'd266;
      1: x = 9'd40;
      2: x = 9'd28;
      default: x = 9'd444;
    endcase
    return {6'd31, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), x, 1'($urandom)};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    logic [63:0] last_pc;
    bit extra;
    rst = 1'b1; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0; start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("reset valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset pc_out", pc_out, 64'h0);
    tick();
    rst = 1'b0;
    checking = 1;

    // Three-word program: add, subf, illegal
    load(0, 32'h7C221A14); load(1, 32'h7C822050); load(2, 32'h0000_0000);
    out_ready = 1'b1;
    pulse_start();
    wait_valid("t1 beat0 valid");
    check("t1 beat0 pc", pc_out, 64'h0);
    check("t1 beat0 rt", rt, 5'd1);
    check("t1 beat0 ra", ra, 5'd2);
    check("t1 beat0 rb", rb, 5'd3);
    check("t1 beat0 xo", xo, 9'd266);
    wait_valid("t1 beat1 valid");
    check("t1 beat1 pc", pc_out, 64'h4);
    check("t1 beat1 xo", xo, 9'd40);
    wait_valid("t1 beat2 valid");
    check("t1 beat2 pc", pc_out, 64'h8);
    check("t1 beat2 illegal", illegal, 1'b1);
    wait_done("t1 done");
    check("t1 busy", busy, 1'b0);

    // Backpressure on beat0
    out_ready = 1'b0;
    pulse_start();
    wait_valid("t2 beat0 valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2 hold valid", out_valid, 1'b1);
      check("t2 hold pc", pc_out, 64'h0);
      check("t2 hold rt", rt, 5'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t2 gap1", out_valid, 1'b0);
    @(negedge clk);
    check("t2 gap2", out_valid, 1'b0);
    @(negedge clk);
    check("t2 beat1 valid", out_valid, 1'b1);
    check("t2 beat1 pc", pc_out, 64'h4);
    wait_done("t2 done");

    // Rc and OE variants
    load(0, 32'h7C221A15); load(1, 32'h7C221E14);
    pulse_start();
    wait_valid("t3 beat0 valid");
    check("t3 rc", rc, 1'b1);
    check("t3 oe0", oe, 1'b0);
    wait_valid("t3 beat1 valid");
    check("t3 oe1", oe, 1'b1);
    check("t3 xo", xo, 9'd266);
    wait_done("t3 done");

    // Full memory: 64 beats, then halt
    for (int i = 0; i < 64; i++) load(i, 32'h7C221A14);
    pulse_start();
    beats = 0; last_pc = '0;
    for (int k = 0; k < 64 * 3 + 40 && done !== 1'b1; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        beats++;
        last_pc = pc_out;
      end
    end
    check("t4 beats", 64'(beats), 64'd64);
    check("t4 last pc", last_pc, 64'hFC);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra = 1;
    end
    check("t4 no extra beat", 64'(extra), 64'd0);

    // Reset while holding a beat
    out_ready = 1'b0;
    pulse_start();
    wait_valid("t5 beat0 valid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5 valid", out_valid, 1'b0);
    check("t5 busy", busy, 1'b0);
    check("t5 pc_out", pc_out, 64'h0);
    check("t5 rt", rt, 5'd0);
    out_ready = 1'b1;
    pulse_start();
    wait_valid("t5 refetch valid");
    check("t5 refetch pc", pc_out, 64'h0);
    check("t5 refetch xo", xo, 9'd266);
    wait_done("t5 done");

    // Write to word 1 while it is being fetched
    load(1, 32'h7C822050); load(2, 32'h0000_0000);
    pulse_start();
    wait_valid("t6 beat0 valid");
    @(posedge clk);
    #1;
    imem_addr = 6'd1; imem_wdata = 32'h7C221E14; imem_we = 1'b1;
    tick();
    imem_we = 1'b0;
    wait_valid("t6 beat1 valid");
    check("t6 old xo", xo, 9'd40);
    check("t6 old oe", oe, 1'b0);
    wait_done("t6 done");
    pulse_start();
    wait_valid("t6 rerun beat0");
    wait_valid("t6 rerun beat1");
    check("t6 new xo", xo, 9'd266);
    check("t6 new oe", oe, 1'b1);
    wait_done("t6 rerun done");

    // Randomized traffic
    for (int i = 0; i < 64; i++) load(i, rand_word());
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      out_ready  = ($urandom % 4) != 0;
      start      = ($urandom % 10) == 0;
      imem_we    = ($urandom % 6) == 0;
      imem_addr  = 6'($urandom);
      imem_wdata = rand_word();
      rst        = ($urandom % 300) == 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; imem_we = 1'b0; out_ready = 1'b1;
    repeat (250) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
